ps_bigreg_assembler: RTL and testbench



---
 rtl/mem_layout_pkg.sv | 23 ++
 rtl/ps_bigreg_assembler.sv | 108 ++++++++++
 tb/tb_ps_bigreg_assembler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_layout_pkg.sv
// Shared mem-map layout definitions for the PS big-register assemblers:
// response codes, assembler state encoding and word/index derivation.
package mem_layout_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } bigreg_state_t;

  function automatic int bigreg_nwords(input int data_width, input int word_width);
    return data_width / word_width;
  endfunction

  // The commit (valid) entry sits directly after the last data word.
  function automatic int bigreg_valid_id(input int base_id, input int data_width,
                                         input int word_width);
    return base_id + bigreg_nwords(data_width, word_width);
  endfunction

endpackage

// File: rtl/ps_bigreg_assembler.sv
// Gathers PS mem-map word writes into a shadow and commits them as one wide
// register on a write to VALID_ID; the committed value is held until the consumer takes it.
module ps_bigreg_assembler
  import mem_layout_pkg::*;
#(
  parameter int DATA_WIDTH    = 256,
  parameter int WORD_WIDTH    = 16,
  parameter int ID_WIDTH      = 8,
  parameter int BASE_ID       = 35,
  parameter int ALLOW_PARTIAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [ID_WIDTH-1:0]   wr_id,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  reg_valid,
  input  logic                  reg_ready,
  output logic                  fresh_clr,
  output logic [1:0]            resp,
  output logic                  resp_valid,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int NWORDS   = bigreg_nwords(DATA_WIDTH, WORD_WIDTH);
  localparam int VALID_ID = bigreg_valid_id(BASE_ID, DATA_WIDTH, WORD_WIDTH);
  localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [ID_WIDTH-1:0] BASE_IDX  = ID_WIDTH'(BASE_ID);
  localparam logic [ID_WIDTH-1:0] VALID_IDX = ID_WIDTH'(VALID_ID);

  bigreg_state_t state, state_nxt;

  logic [NWORDS-1:0][WORD_WIDTH-1:0] shadow;
  logic [NWORDS-1:0]                 mask;
  logic [IDX_W-1:0]                  word_idx;

  logic in_word;
  logic is_commit_id;
  logic mask_full;
  logic commit;
  logic reject_hold;
  logic handshake;

  assign in_word      = wr_valid && (wr_id >= BASE_IDX) && (wr_id < VALID_IDX);
  assign is_commit_id = wr_valid && (wr_id == VALID_IDX);
  assign word_idx     = IDX_W'(wr_id - BASE_IDX);
  assign mask_full    = &mask;

  assign commit      = is_commit_id && (state == COLLECT) && (mask_full || (ALLOW_PARTIAL != 0));
  assign reject_hold = is_commit_id && (state == HOLD);
  assign handshake   = (state == HOLD) && reg_ready;

  assign reg_valid = (state == HOLD);
  assign busy      = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (commit)    state_nxt = HOLD;
      HOLD:    if (handshake) state_nxt = COLLECT;
      default:                state_nxt = COLLECT;
    endcase
  end

  // Only one mem-map write per cycle, so a word store and a commit's mask
  // clear never coincide; a word store alongside a handshake is independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      mask       <= '0;
      reg_data   <= '0;
      fresh_clr  <= 1'b0;
      resp       <= RESP_OKAY;
      resp_valid <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      fresh_clr  <= handshake;
      resp_valid <= in_word || is_commit_id;
      resp       <= (is_commit_id && !commit) ? RESP_SLVERR : RESP_OKAY;

      if (in_word) begin
        shadow[word_idx] <= wr_data;
        mask[word_idx]   <= 1'b1;
      end

      if (commit) begin
        reg_data <= shadow;
        mask     <= '0;
      end

      if (reject_hold && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps_bigreg_assembler.sv
// Scoreboard bench: stimulus pushes expected responses/registers, a negedge monitor pops and compares.
module tb_ps_bigreg_assembler;
  import mem_layout_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         sel_p = 1'b0;
  logic [7:0]   wr_id = 8'd0;
  logic [15:0]  wr_data = 16'd0;
  logic         reg_ready = 1'b0;

  logic         m_wr_valid, p_wr_valid;
  logic [255:0] reg_data, p_reg_data;
  logic         reg_valid, p_reg_valid;
  logic         fresh_clr, p_fresh_clr;
  logic [1:0]   resp, p_resp;
  logic         resp_valid, p_resp_valid;
  logic         busy, p_busy;
  logic [7:0]   drop_count, p_drop_count;

  assign m_wr_valid = wr_valid && !sel_p;
  assign p_wr_valid = wr_valid && sel_p;

  always #5 clk = ~clk;

  ps_bigreg_assembler #(
    .DATA_WIDTH(256), .WORD_WIDTH(16), .ID_WIDTH(8), .BASE_ID(35), .ALLOW_PARTIAL(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(m_wr_valid), .wr_id(wr_id), .wr_data(wr_data),
    .reg_data(reg_data), .reg_valid(reg_valid), .reg_ready(reg_ready),
    .fresh_clr(fresh_clr), .resp(resp), .resp_valid(resp_valid), .busy(busy),
    .drop_count(drop_count)
  );

  ps_bigreg_assembler #(
    .DATA_WIDTH(256), .WORD_WIDTH(16), .ID_WIDTH(8), .BASE_ID(35), .ALLOW_PARTIAL(1)
  ) dut_p (
    .clk(clk), .rst(rst), .wr_valid(p_wr_valid), .wr_id(wr_id), .wr_data(wr_data),
    .reg_data(p_reg_data), .reg_valid(p_reg_valid), .reg_ready(reg_ready),
    .fresh_clr(p_fresh_clr), .resp(p_resp), .resp_valid(p_resp_valid), .busy(p_busy),
    .drop_count(p_drop_count)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]   exp_resp[$];
  logic [1:0]   exp_resp_p[$];
  logic [255:0] exp_reg[$];
  logic [255:0] exp_reg_p[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pat(input logic [15:0] base);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  // Monitor: all DUT outputs sampled on the falling edge.
  bit           wr_prev = 1'b0, pwr_prev = 1'b0, hs_prev = 1'b0;
  bit           rv_prev = 1'b0, prv_prev = 1'b0;
  logic [255:0] held = '0;

  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", {255'd0, resp_valid}, 256'd0);
      else chk("resp", {254'd0, resp}, {254'd0, exp_resp.pop_front()});
    end
    if (wr_prev || resp_valid) chk("resp_valid_latency", {255'd0, resp_valid}, {255'd0, wr_prev});

    if (p_resp_valid) begin
      if (exp_resp_p.size() == 0) chk("p_resp_unexpected", {255'd0, p_resp_valid}, 256'd0);
      else chk("p_resp", {254'd0, p_resp}, {254'd0, exp_resp_p.pop_front()});
    end
    if (pwr_prev || p_resp_valid) chk("p_resp_valid_latency", {255'd0, p_resp_valid}, {255'd0, pwr_prev});

    if (reg_valid && !rv_prev) begin
      if (exp_reg.size() == 0) chk("reg_unexpected", {255'd0, reg_valid}, 256'd0);
      else chk("reg_data", reg_data, exp_reg.pop_front());
    end else if (reg_valid && rv_prev) begin
      chk("reg_stable", reg_data, held);
    end

    if (p_reg_valid && !prv_prev) begin
      if (exp_reg_p.size() == 0) chk("p_reg_unexpected", {255'd0, p_reg_valid}, 256'd0);
      else chk("p_reg_data", p_reg_data, exp_reg_p.pop_front());
    end

    if (fresh_clr || hs_prev) chk("fresh_clr", {255'd0, fresh_clr}, {255'd0, hs_prev});

    wr_prev  = m_wr_valid && (wr_id >= 8'd35) && (wr_id <= 8'd51) && !rst;
    pwr_prev = p_wr_valid && (wr_id >= 8'd35) && (wr_id <= 8'd51) && !rst;
    hs_prev  = reg_valid && reg_ready && !rst;
    rv_prev  = reg_valid;
    prv_prev = p_reg_valid;
    held     = reg_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write per call; called just after a rising edge, returns just after the sampling edge.
  task automatic wr(input int id, input logic [15:0] d, input logic p, input logic [1:0] er);
    logic [31:0] idv;
    idv = id;
    sel_p = p;
    wr_valid = 1'b1;
    wr_id = idv[7:0];
    wr_data = d;
    if (id >= 35 && id <= 51) begin
      if (p) exp_resp_p.push_back(er);
      else exp_resp.push_back(er);
    end
    step();
    wr_valid = 1'b0;
    sel_p = 1'b0;
  endtask

  task automatic wr_all(input logic [15:0] base);
    for (int k = 0; k < 16; k++) wr(35 + k, base + 16'(k), 1'b0, RESP_OKAY);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_reg_valid", {255'd0, reg_valid}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_drop", {248'd0, drop_count}, 256'd0);
    chk("rst_reg_data", reg_data, 256'd0);
    chk("rst_resp_valid", {255'd0, resp_valid}, 256'd0);
    chk("rst_fresh", {255'd0, fresh_clr}, 256'd0);
    step();

    // Out-of-range ids are ignored; empty mask commit is refused
    wr(34, 16'h1111, 1'b0, RESP_OKAY);
    wr(52, 16'h2222, 1'b0, RESP_OKAY);
    wr(51, 16'h0000, 1'b0, RESP_SLVERR);
    @(negedge clk);
    chk("oor_no_commit", {255'd0, reg_valid}, 256'd0);
    step();

    // Full write then commit with consumer ready
    reg_ready = 1'b1;
    wr_all(16'h1000);
    exp_reg.push_back(pat(16'h1000));
    wr(51, 16'h0000, 1'b0, RESP_OKAY);
    @(negedge clk);
    chk("commit_reg_valid", {255'd0, reg_valid}, {255'd0, 1'b1});
    chk("commit_busy", {255'd0, busy}, {255'd0, 1'b1});
    step();
    repeat (3) step();

    // Incomplete mask refused, completed afterwards
    for (int k = 0; k < 16; k++)
      if (k != 7) wr(35 + k, 16'h3000 + 16'(k), 1'b0, RESP_OKAY);
    wr(51, 16'h0000, 1'b0, RESP_SLVERR);
    @(negedge clk);
    chk("partial_refused", {255'd0, reg_valid}, 256'd0);
    step();
    wr(42, 16'h3007, 1'b0, RESP_OKAY);
    exp_reg.push_back(pat(16'h3000));
    wr(51, 16'h0000, 1'b0, RESP_OKAY);
    repeat (3) step();

    // Commit while consumer stalls, second commit dropped in HOLD
    reg_ready = 1'b0;
    wr_all(16'h1000);
    exp_reg.push_back(pat(16'h1000));
    wr(51, 16'h0000, 1'b0, RESP_OKAY);
    wr_all(16'h2000);
    wr(51, 16'h0000, 1'b0, RESP_SLVERR);
    @(negedge clk);
    chk("hold_drop1", {248'd0, drop_count}, 256'd1);
    chk("hold_busy", {255'd0, busy}, {255'd0, 1'b1});
    chk("hold_reg_data", reg_data, pat(16'h1000));
    step();
    reg_ready = 1'b1;
    repeat (2) step();
    exp_reg.push_back(pat(16'h2000));
    wr(51, 16'h0000, 1'b0, RESP_OKAY);
    repeat (3) step();

    // drop_count saturation, then reset in HOLD with ready high
    reg_ready = 1'b0;
    wr_all(16'h4000);
    exp_reg.push_back(pat(16'h4000));
    wr(51, 16'h0000, 1'b0, RESP_OKAY);
    for (int i = 0; i < 256; i++) wr(51, 16'h0000, 1'b0, RESP_SLVERR);
    @(negedge clk);
    chk("drop_saturated", {248'd0, drop_count}, 256'd255);
    step();
    rst = 1'b1;
    reg_ready = 1'b1;
    step();
    rst = 1'b0;
    reg_ready = 1'b0;
    @(negedge clk);
    chk("hold_rst_reg_valid", {255'd0, reg_valid}, 256'd0);
    chk("hold_rst_drop", {248'd0, drop_count}, 256'd0);
    chk("hold_rst_busy", {255'd0, busy}, 256'd0);
    chk("hold_rst_fresh", {255'd0, fresh_clr}, 256'd0);
    chk("hold_rst_reg_data", reg_data, 256'd0);
    step();

    // ALLOW_PARTIAL instance: single word then commit
    wr(38, 16'hBEEF, 1'b1, RESP_OKAY);
    begin
      logic [255:0] e;
      e = '0;
      e[63:48] = 16'hBEEF;
      exp_reg_p.push_back(e);
    end
    wr(51, 16'h0000, 1'b1, RESP_OKAY);
    @(negedge clk);
    chk("p_commit_valid", {255'd0, p_reg_valid}, {255'd0, 1'b1});
    chk("p_main_untouched", {255'd0, reg_valid}, 256'd0);
    step();
    repeat (3) step();

    chk("resp_queue_drained", 256'(exp_resp.size()), 256'd0);
    chk("p_resp_queue_drained", 256'(exp_resp_p.size()), 256'd0);
    chk("reg_queue_drained", 256'(exp_reg.size()), 256'd0);
    chk("p_reg_queue_drained", 256'(exp_reg_p.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
